phase_array_ctrl: RTL and testbench
===================================

# phase_array_ctrl

Parametrised phased-array drive controller: a shared period counter generates CHANNELS square-wave transducer drives, and each channel has its own programmable phase offset and enable. A byte-level command decoder sits on the UART's AXI-stream byte interface and programs double-buffered (shadow/active) phase registers. Shadow values move to the active set glitch-free at a period boundary. The block replaces free-running per-channel oscillators at the top of the levitator FPGA.

## Interface
- CHANNELS, 16: number of drive outputs, 1..128
- PERIOD, 1250: drive period in clk cycles (50 MHz / 40 kHz); even, 4..16384
- PHASE_WIDTH, 11: offset register width, must equal clog2(PERIOD)
- RESET_STEP, 10: reset offset of channel i is (i*RESET_STEP) mod PERIOD
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- tx  out  CHANNELS  transducer drive outputs, registered
- sync_out  out  1  one-cycle pulse when the period counter is 0
- rx_data  in  8  command byte from UART receiver
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid && rx_ready
- resp_data  out  8  response byte to UART transmitter
- resp_valid  out  1  resp_data valid, held until accepted
- resp_ready  in  1  transmitter accepts when resp_valid && resp_ready
- commit_pending  out  1  COMMIT issued, not yet applied

## Operation
- Period counter cnt runs 0..PERIOD-1 and wraps to 0.
- Channel i output: tx[i] <= en_act[i] && (((cnt - off_act[i]) mod PERIOD) < PERIOD/2). Compute the subtraction in PHASE_WIDTH+1 bits, adding PERIOD when the result is negative.
- Frame is 4 bytes:
  - B0 = {1, op[6:0]}
  - B1 = {0, chan[6:0]}
  - B2 = {0, hi[6:0]}
  - B3 = {0, lo[6:0]}
  - value = {hi, lo} (14 bits).
- Frame decoder states:
  - IDLE: byte with bit7=1 -> HAVE_OP. Byte with bit7=0 is dropped, no response.
  - HAVE_OP, HAVE_CH, HAVE_HI: byte with bit7=0 advances to the next state. Byte with bit7=1 aborts the current frame silently and starts a new one, staying in HAVE_OP.
  - HAVE_HI plus a bit7=0 byte completes the frame -> EXEC.
  - EXEC: perform the action, load the response, return to IDLE.
- Ops, each ACKed with resp = 0x80|op:
  - 0x00 SET_PHASE: off_sh[chan] <= value. NAK if chan >= CHANNELS or value >= PERIOD.
  - 0x01 SET_ENABLE: en_sh[chan] <= value[0]. NAK if chan >= CHANNELS.
  - 0x02 COMMIT: set commit_pending. chan and value are ignored.
  - 0x03 GLOBAL_ENABLE: all en_sh <= value[0].
  - 0x04 RESTORE: off_sh <= reset defaults, en_sh <= all 1.
- Any other op, or a failed range check: resp = 0xFF (NAK), and no state changes.
- Apply: on a cycle with cnt == PERIOD-1 and commit_pending registered 1:
  - off_act <= off_sh, en_act <= en_sh
  - commit_pending <= 0.
- Every completed frame produces exactly one response byte. Aborted or dropped bytes produce none.

## Timing
- Reset values:
  - tx = 0, sync_out = 0, cnt = 0
  - resp_valid = 0, resp_data = 0, rx_ready = 0, commit_pending = 0
  - off_sh = off_act = defaults
  - en_sh = en_act = all 1
  - decoder in IDLE.
- rx_ready = 1 in every non-EXEC state while resp_valid = 0. It drops to 0 from EXEC until the response is accepted, giving backpressure with no byte loss.
- The byte completing a frame is accepted in cycle N:
  - EXEC at N+1
  - resp_valid = 1 and register write visible at N+2
  - resp_valid clears the cycle after the resp_valid && resp_ready handshake.
- tx[i] lags cnt by 1 cycle. sync_out is registered and aligned with tx, so it is high in the cycle after cnt == 0.
- COMMIT whose EXEC is the cnt == PERIOD-1 cycle: commit_pending is not yet registered, so it applies at the following wrap. Worst-case apply latency is PERIOD+2 cycles after the final byte.
- SET_* EXEC in the same cycle as an apply: the apply copies the pre-write shadow value, and the write lands in shadow only.
- A second COMMIT while one is pending is ACKed with no extra effect.
- Reset asserted mid-frame or mid-response: all state returns to the reset values immediately, and any partial frame is discarded.

## Test plan
- Reset release, no commands -> ch0 rises at cycle 1, ch1 is 10 cycles later, each output 625 high / 625 low; sync_out pulses every 1250 cycles.
- SET_PHASE ch3 = 625 (0x80 0x03 0x04 0x71) then COMMIT -> responses 0x80, 0x82. tx[3] changes only at the period boundary after the commit, then runs inverted relative to the default-0 reference channel; no runt pulse.
- SET_PHASE with chan = 20, and separately with value = 1250 -> 0xFF each; the shadow registers are unchanged (check after COMMIT).
- Bytes 0x80 0x02 0x81 0x05 0x00 0x00 -> the first frame is silently aborted; one response 0x81; en_sh[5] = 0, and tx[5] is held low after COMMIT.
- resp_ready held 0 for 50 cycles after a frame -> rx_ready = 0 throughout, the next frame's bytes stall, and no byte is lost after release.
- COMMIT frame finishing so that EXEC lands on cnt = 1249 -> the apply occurs at the next wrap, 1250 cycles later; commit_pending stays 1 until then.

Source files
------------

// File: rtl/phase_array_if.sv
// phase_array_if: command byte stream in and response byte stream out of the phased-array controller.
interface phase_array_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] resp_data;
    logic       resp_valid;
    logic       resp_ready;
    modport master (output rx_data, rx_valid, resp_ready, input rx_ready, resp_data, resp_valid);
    modport slave (input rx_data, rx_valid, resp_ready, output rx_ready, resp_data, resp_valid);
endinterface

// File: rtl/phase_array_ctrl.sv
// phase_array_ctrl: shared-period square-wave drives with per-channel phase/enable,
// programmed through a 4-byte command decoder into shadow registers applied at a period wrap.
module phase_array_ctrl #(
    parameter int CHANNELS    = 16,
    parameter int PERIOD      = 1250,
    parameter int PHASE_WIDTH = 11,
    parameter int RESET_STEP  = 10
) (
    input  logic                clk,
    input  logic                rst,
    phase_array_if.slave        bus,
    output logic [CHANNELS-1:0] tx,
    output logic                sync_out,
    output logic                commit_pending
);
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam logic [PHASE_WIDTH:0] P_EXT = PERIOD;
    localparam logic [PHASE_WIDTH:0] HALF = PERIOD / 2;
    typedef enum logic [2:0] {IDLE, HAVE_OP, HAVE_CH, HAVE_HI, EXEC} state_t;
    state_t                 state;
    logic [PHASE_WIDTH-1:0] cnt;
    logic [PHASE_WIDTH-1:0] off_sh  [CHANNELS];
    logic [PHASE_WIDTH-1:0] off_act [CHANNELS];
    logic [CHANNELS-1:0]    en_sh, en_act, drive;
    logic [6:0]             op, chan, hi, lo;
    logic [13:0]            value;
    logic                   wrap, take, done, chan_ok, value_ok;

    function automatic logic [PHASE_WIDTH-1:0] def_off(input int i);
        return PHASE_WIDTH'((i * RESET_STEP) % PERIOD);
    endfunction

    assign value    = {hi, lo};
    assign wrap     = cnt == PHASE_WIDTH'(PERIOD - 1);
    assign take     = bus.rx_valid && bus.rx_ready;
    assign done     = take && state == HAVE_HI && !bus.rx_data[7];
    assign chan_ok  = int'(chan) < CHANNELS;
    assign value_ok = int'(value) < PERIOD;

    // Phase difference wraps into 0..PERIOD-1; first half of the period drives high.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [PHASE_WIDTH:0] d;
        assign d = {1'b0, cnt} - {1'b0, off_act[i]};
        assign drive[i] = en_act[i] && ((d[PHASE_WIDTH] ? d + P_EXT : d) < HALF);
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt      <= '0;
            tx       <= '0;
            sync_out <= 1'b0;
        end else begin
            cnt      <= wrap ? '0 : cnt + 1'b1;
            tx       <= drive;
            sync_out <= cnt == '0;
        end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) off_act[i] <= def_off(i);
            en_act <= '1;
        end else if (wrap && commit_pending) begin
            off_act <= off_sh;
            en_act  <= en_sh;
        end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state          <= IDLE;
            op             <= '0;
            chan           <= '0;
            hi             <= '0;
            lo             <= '0;
            bus.rx_ready   <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= '0;
            commit_pending <= 1'b0;
            en_sh          <= '1;
            for (int i = 0; i < CHANNELS; i++) off_sh[i] <= def_off(i);
        end else begin
            bus.rx_ready <= !(state == EXEC || done || (bus.resp_valid && !bus.resp_ready));
            if (bus.resp_valid && bus.resp_ready) bus.resp_valid <= 1'b0;
            // A COMMIT executing on the apply cycle re-arms after the copy.
            if (wrap && commit_pending) commit_pending <= 1'b0;
            if (state == EXEC) begin
                state          <= IDLE;
                bus.resp_valid <= 1'b1;
                bus.resp_data  <= {1'b1, op};
                case (op)
                    7'd0: if (chan_ok && value_ok) off_sh[chan[CW-1:0]] <= value[PHASE_WIDTH-1:0];
                          else bus.resp_data <= 8'hff;
                    7'd1: if (chan_ok) en_sh[chan[CW-1:0]] <= lo[0];
                          else bus.resp_data <= 8'hff;
                    7'd2: commit_pending <= 1'b1;
                    7'd3: en_sh <= {CHANNELS{lo[0]}};
                    7'd4: begin
                        en_sh <= '1;
                        for (int i = 0; i < CHANNELS; i++) off_sh[i] <= def_off(i);
                    end
                    default: bus.resp_data <= 8'hff;
                endcase
            end else if (take) begin
                if (bus.rx_data[7]) begin
                    op    <= bus.rx_data[6:0];
                    state <= HAVE_OP;
                end else begin
                    case (state)
                        HAVE_OP: begin chan <= bus.rx_data[6:0]; state <= HAVE_CH; end
                        HAVE_CH: begin hi <= bus.rx_data[6:0]; state <= HAVE_HI; end
                        HAVE_HI: begin lo <= bus.rx_data[6:0]; state <= EXEC; end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
endmodule

// File: tb/tb_phase_array_ctrl.sv
// tb_phase_array_ctrl: directed command frames with a response scoreboard plus drive-waveform checks.
module tb_phase_array_ctrl;
    logic        clk = 0;
    logic        rst = 0;
    logic [15:0] tx;
    logic        sync_out, commit_pending;
    int          checks = 0, errors = 0, cyc = 0;
    logic [7:0]  exp_q [$];
    bit          sent2;

    phase_array_if bus ();

    phase_array_ctrl dut (
        .clk(clk), .rst(rst), .bus(bus), .tx(tx), .sync_out(sync_out), .commit_pending(commit_pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst)
        if (!rst) cyc <= 0;
        else cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk)
        if (rst && bus.resp_valid && bus.resp_ready) begin
            if (exp_q.size() == 0) chk("unexpected_resp", int'(bus.resp_data), -1);
            else chk("resp", int'(bus.resp_data), int'(exp_q.pop_front()));
        end

    // Drive of a channel with offset off, sampled after posedge k following reset release.
    function automatic bit exp_tx(input int off, input int k);
        int c;
        c = (((k - 1 - off) % 1250) + 1250) % 1250;
        return c < 625;
    endfunction

    task automatic send(input logic [7:0] b);
        int n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1;
        while (!bus.rx_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rx_ready) chk("rx_timeout", 0, 1);
        @(negedge clk);
        bus.rx_valid = 0;
    endtask

    task automatic frame(input logic [7:0] b0, b1, b2, b3, input logic [7:0] r);
        exp_q.push_back(r);
        send(b0); send(b1); send(b2); send(b3);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic commit_and_apply();
        int n = 0;
        frame(8'h82, 0, 0, 0, 8'h82);
        repeat (2) @(negedge clk);
        chk("pending_set", int'(commit_pending), 1);
        while (commit_pending && n < 1400) begin
            @(negedge clk);
            n++;
        end
        chk("apply_done", int'(commit_pending), 0);
    endtask

    initial begin
        int bad0, bad1, bad15, bads, hi0, bad3, bad5, s, n;
        bus.rx_valid = 0;
        bus.rx_data = 0;
        bus.resp_ready = 1;
        repeat (3) @(negedge clk);
        chk("rst_tx", int'(tx), 0);
        chk("rst_sync", int'(sync_out), 0);
        chk("rst_rx_ready", int'(bus.rx_ready), 0);
        chk("rst_resp_valid", int'(bus.resp_valid), 0);
        chk("rst_resp_data", int'(bus.resp_data), 0);
        chk("rst_pending", int'(commit_pending), 0);
        rst = 1;

        bad0 = 0; bad1 = 0; bad15 = 0; bads = 0; hi0 = 0;
        for (int k = 1; k <= 1260; k++) begin
            @(negedge clk);
            if (k == 1) chk("ch0_rise_c1", int'(tx[0]), 1);
            if (k == 10) chk("ch1_low_c10", int'(tx[1]), 0);
            if (k == 11) chk("ch1_rise_c11", int'(tx[1]), 1);
            if (k <= 1250) hi0 += int'(tx[0]);
            if (tx[0] != exp_tx(0, k)) bad0++;
            if (tx[1] != exp_tx(10, k)) bad1++;
            if (tx[15] != exp_tx(150, k)) bad15++;
            if (sync_out != ((k - 1) % 1250 == 0)) bads++;
        end
        chk("ch0_wave", bad0, 0);
        chk("ch1_wave", bad1, 0);
        chk("ch15_wave", bad15, 0);
        chk("sync_wave", bads, 0);
        chk("ch0_high_count", hi0, 625);

        frame(8'h80, 8'h03, 8'h04, 8'h71, 8'h80);
        exp_q.push_back(8'h82);
        send(8'h82); send(0); send(0); send(0);
        repeat (2) @(negedge clk);
        chk("pending_after_commit", int'(commit_pending), 1);
        bad3 = 0; n = 0;
        while (commit_pending && n < 1400) begin
            if (tx[3] != exp_tx(30, cyc)) bad3++;
            @(negedge clk);
            n++;
        end
        chk("ch3_old_until_apply", bad3, 0);
        chk("apply_timeout", int'(commit_pending), 0);
        bad3 = 0; bad0 = 0;
        repeat (1250) begin
            @(negedge clk);
            if (tx[3] != !tx[0]) bad3++;
            if (tx[0] != exp_tx(0, cyc)) bad0++;
        end
        chk("ch3_inverted", bad3, 0);
        chk("ch0_ref", bad0, 0);

        frame(8'h80, 8'h14, 8'h00, 8'h05, 8'hff);
        frame(8'h80, 8'h03, 8'h09, 8'h62, 8'hff);
        commit_and_apply();
        bad3 = 0;
        repeat (1250) begin
            @(negedge clk);
            if (tx[3] != !tx[0]) bad3++;
        end
        chk("ch3_unchanged_after_nak", bad3, 0);

        exp_q.push_back(8'h81);
        send(8'h80); send(8'h02); send(8'h81); send(8'h05); send(8'h00); send(8'h00);
        commit_and_apply();
        bad5 = 0; bad1 = 0;
        repeat (1250) begin
            @(negedge clk);
            if (tx[5] != 0) bad5++;
            if (tx[6] != exp_tx(60, cyc)) bad1++;
        end
        chk("ch5_disabled", bad5, 0);
        chk("ch6_running", bad1, 0);
        drain();

        bus.resp_ready = 0;
        frame(8'h80, 8'h04, 8'h00, 8'h64, 8'h80);
        sent2 = 0;
        fork
            begin
                exp_q.push_back(8'hff);
                send(8'h85); send(0); send(0); send(0);
                sent2 = 1;
            end
        join_none
        bads = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.rx_ready) bads++;
        end
        chk("rx_ready_held_low", bads, 0);
        chk("resp_held", int'(bus.resp_valid), 1);
        chk("queue_stalled", exp_q.size(), 2);
        bus.resp_ready = 1;
        n = 0;
        while (!sent2 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("second_frame_sent", int'(sent2), 1);
        drain();

        frame(8'h80, 8'h03, 8'h00, 8'h00, 8'h80);
        drain();
        exp_q.push_back(8'h82);
        send(8'h82); send(0); send(0);
        n = 0;
        while (cyc % 1250 != 1248 && n < 1300) begin
            @(negedge clk);
            n++;
        end
        s = cyc;
        send(8'h00);
        @(negedge clk);
        chk("late_commit_pending", int'(commit_pending), 1);
        n = 0;
        while (commit_pending && n < 1400) begin
            @(negedge clk);
            n++;
        end
        chk("late_commit_latency", cyc - s, 1252);
        bad3 = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx[3] != tx[0]) bad3++;
        end
        chk("ch3_phase0", bad3, 0);
        drain();

        send(8'h80); send(8'h03);
        rst = 0;
        #1;
        chk("midrst_tx", int'(tx), 0);
        chk("midrst_rx_ready", int'(bus.rx_ready), 0);
        chk("midrst_pending", int'(commit_pending), 0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("midrst_ch0_c1", int'(tx[0]), 1);
        send(8'h00); send(8'h00); send(8'h00);
        frame(8'h81, 8'h05, 8'h00, 8'h01, 8'h81);
        drain();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
